// File: rtl/lock_code_controller.sv
// -----------------------------------------------------------------------------
// lock_code_controller
//
// Sequencing controller for the 4-digit hex code lock. It turns debounced
// single-cycle button pulses into a 4-nibble entry buffer and holds the
// stored code. It runs the SET / LOCKED / UNLOCKED / ALARM state machine,
// whose outputs feed the seven-segment display driver directly.
//
// Parameters:
//   TIMEOUT_CYCLES  auto-relock delay in UNLOCKED and ALARM duration (>= 2)
//   MAX_FAILS       consecutive wrong codes that trigger ALARM (1..3)
//
// Ports:
//   clock       single clock for the whole block
//   reset       synchronous, active-high
//   btn_up      pulse: increment digit under cursor (mod 16)
//   btn_next    pulse: advance cursor (mod 4)
//   btn_enter   pulse: commit (SET) / compare (LOCKED) / relock (UNLOCKED)
//   state       display code: 00 = I (SET), 01 = L (LOCKED/ALARM), 10 = U
//   hex1..hex4  entry digits 0..3 (hex1 is the leftmost digit)
//   cursor      index of the editable digit
//   fail_count  consecutive wrong attempts (saturates at MAX_FAILS)
//   alarm       high only while in ALARM
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module lock_code_controller #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [1:0] state,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [1:0] cursor,
  output logic [1:0] fail_count,
  output logic       alarm
);

  localparam int             TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
  localparam logic [1:0]     FAIL_LIMIT = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_SET,
    ST_LOCKED,
    ST_UNLOCKED,
    ST_ALARM
  } fsm_t;

  fsm_t            fsm, fsm_next;
  logic [3:0][3:0] entry, entry_next;
  logic [15:0]     code, code_next;
  logic [TW-1:0]   timer, timer_next;
  logic [1:0]      cursor_next;
  logic [1:0]      fail_next;
  logic [1:0]      state_next;
  logic            alarm_next;

  // Only the highest-priority pulse of a cycle acts: enter > next > up.
  logic do_enter, do_next, do_up;
  assign do_enter = btn_enter;
  assign do_next  = btn_next & ~btn_enter;
  assign do_up    = btn_up & ~btn_next & ~btn_enter;

  // Next-state and datapath logic. The timer defaults to 0, which keeps it
  // held in SET/LOCKED and restarts it on a pulse in UNLOCKED; it only
  // advances where explicitly counted below.
  always_comb begin
    fsm_next    = fsm;
    entry_next  = entry;
    cursor_next = cursor;
    fail_next   = fail_count;
    code_next   = code;
    timer_next  = '0;

    case (fsm)
      ST_SET: begin
        if (do_enter) begin
          code_next = entry;
          fsm_next  = ST_LOCKED;
        end else if (do_next) begin
          cursor_next = cursor + 2'd1;
        end else if (do_up) begin
          entry_next[cursor] = entry[cursor] + 4'd1;
        end
      end

      ST_LOCKED: begin
        if (do_enter) begin
          if (entry == code) begin
            fsm_next  = ST_UNLOCKED;
            fail_next = '0;
          end else begin
            // A wrong attempt clears the entry even when staying LOCKED.
            entry_next  = '0;
            cursor_next = '0;
            if (fail_count >= FAIL_LIMIT - 2'd1) begin
              fail_next = FAIL_LIMIT;
              fsm_next  = ST_ALARM;
            end else begin
              fail_next = fail_count + 2'd1;
            end
          end
        end else if (do_next) begin
          cursor_next = cursor + 2'd1;
        end else if (do_up) begin
          entry_next[cursor] = entry[cursor] + 4'd1;
        end
      end

      ST_UNLOCKED: begin
        // A next pulse only restarts the timer, even in the timeout cycle.
        if (do_enter) begin
          fsm_next = ST_LOCKED;
        end else if (do_next) begin
          timer_next = '0;
        end else if (do_up) begin
          fsm_next = ST_SET;
        end else if (timer == TIMER_LAST) begin
          fsm_next = ST_LOCKED;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end

      ST_ALARM: begin
        if (timer == TIMER_LAST) begin
          fsm_next  = ST_LOCKED;
          fail_next = '0;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end

      default: begin
        fsm_next = ST_SET;
      end
    endcase

    // Any state change starts the new state with a clean entry and timer.
    if (fsm_next != fsm) begin
      entry_next  = '0;
      cursor_next = '0;
      timer_next  = '0;
    end

    case (fsm_next)
      ST_SET:      state_next = 2'b00;
      ST_UNLOCKED: state_next = 2'b10;
      default:     state_next = 2'b01;
    endcase
    alarm_next = (fsm_next == ST_ALARM);
  end

  // State and output registers; reset overrides any same-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm        <= ST_SET;
      entry      <= '0;
      cursor     <= '0;
      fail_count <= '0;
      code       <= '0;
      timer      <= '0;
      state      <= 2'b00;
      alarm      <= 1'b0;
    end else begin
      fsm        <= fsm_next;
      entry      <= entry_next;
      cursor     <= cursor_next;
      fail_count <= fail_next;
      code       <= code_next;
      timer      <= timer_next;
      state      <= state_next;
      alarm      <= alarm_next;
    end
  end

  assign hex1 = entry[0];
  assign hex2 = entry[1];
  assign hex3 = entry[2];
  assign hex4 = entry[3];

endmodule

// File: doc/lock_code_controller.md
# lock_code_controller

Sequencing controller for the board's 4-digit hex code lock. It turns single-cycle button pulses into a 4-nibble entry buffer. It holds the stored code and runs the set/locked/unlocked/alarm state machine. Its `state` and `hex1`..`hex4` outputs drive the 8-digit seven-segment display driver directly: `state` encodes I/L/U, and `hex1` is the leftmost code digit.

## Interface
- `TIMEOUT_CYCLES`, default 100000000: cycles before auto-relock in UNLOCKED and duration of ALARM; must be ≥ 2.
- `MAX_FAILS`, default 3: consecutive wrong codes that trigger ALARM; range 1..3.
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high.
- `btn_up`  in  1: one-cycle pulse (already debounced); increments the digit under the cursor.
- `btn_next`  in  1: one-cycle pulse; advances the cursor.
- `btn_enter`  in  1: one-cycle pulse; commits or compares the entry.
- `state`  out  2: display code. 00 = I (SET), 01 = L (LOCKED or ALARM), 10 = U (UNLOCKED). 11 is never driven.
- `hex1`..`hex4`  out  4 each: entry digits 0..3 (`hex1` is digit 0).
- `cursor`  out  2: index of the editable digit.
- `fail_count`  out  2: consecutive wrong attempts.
- `alarm`  out  1: high only while in ALARM.

## Operation
- Internal FSM states: SET, LOCKED, UNLOCKED, ALARM. All outputs are registered.
- Entry buffer: four 4-bit digits.
  - `btn_up` increments digit[cursor] mod 16 (F→0).
  - `btn_next` increments cursor mod 4 (3→0).
- Per-cycle input priority: `btn_enter` > `btn_next` > `btn_up`. Only the highest-priority pulse present acts; the others are discarded.
- On every FSM transition, the entry buffer and cursor clear to 0.
- SET:
  - Up and next edit the entry.
  - Enter copies the entry into the stored code, then goes to LOCKED. `fail_count` is not changed.
- LOCKED:
  - Up and next edit the entry.
  - Enter compares all 16 bits of the entry, as held in that cycle, against the stored code.
  - On a match: go to UNLOCKED and set `fail_count` to 0.
  - On a mismatch: `fail_count` +1, and the entry and cursor clear while staying in LOCKED.
  - If the incremented value equals `MAX_FAILS`, go to ALARM instead.
- UNLOCKED:
  - Enter goes to LOCKED (manual relock).
  - Up goes to SET (code change).
  - Next has no effect other than restarting the timer.
  - With no pulse for `TIMEOUT_CYCLES` cycles, go to LOCKED.
- ALARM:
  - All buttons are ignored. `alarm` is 1 and `state` is 01.
  - After `TIMEOUT_CYCLES` cycles, go to LOCKED with `fail_count` set to 0.
- Timer: `$clog2(TIMEOUT_CYCLES)` bits wide. It clears on entry to UNLOCKED or ALARM and on any button pulse in UNLOCKED.
  - It increments each other cycle in those states.
  - The timeout transition fires in the cycle the timer equals `TIMEOUT_CYCLES`-1.
  - The timer is held at 0 in SET and LOCKED.
- `fail_count` saturates; it never exceeds `MAX_FAILS`.

## Timing
- Reset values (applied in the cycle `reset` is sampled high, including mid-operation):
  - FSM = SET, so `state` = 00.
  - `hex1`..`hex4` = 0, `cursor` = 0, `fail_count` = 0, `alarm` = 0.
  - Stored code = 0x0000 and timer = 0.
- Reset overrides any same-cycle button pulse.
- Latency: a pulse sampled at edge N is reflected on all outputs after edge N; one-cycle latency, no combinational input-to-output path.
- Back-to-back pulses on consecutive cycles are each honoured.
- A pulse coincident with the timeout cycle in UNLOCKED:
  - Enter or up wins over the timeout.
  - Next restarts the timer; no relock.
- ALARM lasts exactly `TIMEOUT_CYCLES` cycles from the first cycle with `alarm` = 1.
- UNLOCKED with no input lasts exactly `TIMEOUT_CYCLES` cycles.

## Test plan
- Use `TIMEOUT_CYCLES`=8 and `MAX_FAILS`=3 for all scenarios.
- Set and unlock:
  - Stimulus: after reset, enter digits 1,2,3,4 via up/next pulses, then enter.
  - Required: `state` 01 and all hex outputs 0.
  - Stimulus: re-enter 1,2,3,4, then enter.
  - Required: `state` 10 one cycle after the enter pulse, with `fail_count` 0.
- Wrap-around:
  - Stimulus: 17 up pulses on digit 0.
  - Required: `hex1` = 1.
  - Stimulus: 5 next pulses.
  - Required: `cursor` = 1.
- Lockout:
  - Stimulus: from LOCKED with code 1234, three enters of 0000.
  - Required: `fail_count` 1, 2, then `alarm`=1 with `state` 01.
  - Required: up/next/enter ignored for 8 cycles, then `alarm`=0, `fail_count`=0, LOCKED.
- Auto-relock and tie:
  - Stimulus: in UNLOCKED, hold all inputs idle.
  - Required: `state` returns to 01 exactly 8 cycles after entry.
  - Stimulus: a next pulse in cycle 7.
  - Required: the relock is postponed by a full 8 cycles.
- Priority:
  - Stimulus: in LOCKED, simultaneous up+next+enter with a correct entry.
  - Required: unlock occurs, and the digit and cursor are unchanged before the clear.
  - Stimulus: simultaneous up+next.
  - Required: only the cursor advances.
- Reset mid-operation:
  - Stimulus: assert `reset` during ALARM with an enter pulse in the same cycle.
  - Required: next cycle `state` 00, `alarm` 0, all counters 0.
  - Required: the stored code is 0000, so an enter in LOCKED with all zeros unlocks.
